// File: rtl/keypad_debouncer_param_if.sv
// Purpose: keypad debouncer bus; groups the scanner inputs and debounced outputs.
// Signals:
//   key_valid  scanner reports a key down
//   key_code   scanned key code, meaningful only when key_valid=1
//   pulse      one-cycle strobe per confirmed press (and per repeat)
//   deb_code   code of the last confirmed key
//   held       high from press confirm until release confirm
// Modports: master drives scanner side (testbench/scanner), slave is the debouncer.
interface keypad_debouncer_param_if #(
   parameter int unsigned CODE_W = 4
);
   logic              key_valid;
   logic [CODE_W-1:0] key_code;
   logic              pulse;
   logic [CODE_W-1:0] deb_code;
   logic              held;

   modport master (
      output key_valid, key_code,
      input  pulse, deb_code, held
   );

   modport slave (
      input  key_valid, key_code,
      output pulse, deb_code, held
   );
endinterface

// File: rtl/keypad_debouncer_param.sv
// Purpose: keypad debouncer requiring both press and release to be stable for
// STABLE_CYCLES clocks; emits a one-cycle pulse with a latched code per press.
// Optional auto-repeat is built when the macro AUTO_REPEAT_EN is defined.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    slave side of keypad_debouncer_param_if (key_valid/key_code in,
//          pulse/deb_code/held out, all outputs registered)
module keypad_debouncer_param #(
   parameter int unsigned CODE_W        = 4,
   parameter int unsigned STABLE_CYCLES = 16384,
   parameter int unsigned REPEAT_DELAY  = 6000000,
   parameter int unsigned REPEAT_RATE   = 1200000
) (
   input  logic                      clk,
   input  logic                      reset,
   keypad_debouncer_param_if.slave   bus
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   localparam logic [1:0] S_IDLE            = 2'd0;
   localparam logic [1:0] S_CONFIRM         = 2'd1;
   localparam logic [1:0] S_PRESSED         = 2'd2;
   localparam logic [1:0] S_RELEASE_CONFIRM = 2'd3;

   // Elaboration-time parameter sanity; repeat intervals below 2 would allow back-to-back pulses.
   if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("STABLE_CYCLES must be >= 2");
   end
   if (REPEAT_DELAY < 2 || REPEAT_RATE < 2) begin : g_bad_repeat
      $error("REPEAT_DELAY and REPEAT_RATE must be >= 2");
   end

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CODE_W-1:0] sample_q, sample_d;
   logic [CODE_W-1:0] deb_code_q, deb_code_d;
   logic              held_q, held_d;
   logic              pulse_q, pulse_d;
   logic              match_sample_c;
   logic              match_deb_c;

`ifdef AUTO_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned REP_W   = $clog2(REP_MAX);
   // Down-counter: cycles remaining until the next repeat pulse.
   logic [REP_W-1:0] rep_q, rep_d;
`endif

   assign match_sample_c = bus.key_valid && (bus.key_code == sample_q);
   assign match_deb_c    = bus.key_valid && (bus.key_code == deb_code_q);

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         sample_q   <= '0;
         deb_code_q <= '0;
         held_q     <= 1'b0;
         pulse_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
         rep_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sample_q   <= sample_d;
         deb_code_q <= deb_code_d;
         held_q     <= held_d;
         pulse_q    <= pulse_d;
`ifdef AUTO_REPEAT_EN
         rep_q      <= rep_d;
`endif
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sample_d   = sample_q;
      deb_code_d = deb_code_q;
      held_d     = held_q;
      pulse_d    = 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_d      = rep_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.key_valid) begin
               sample_d = bus.key_code;
               cnt_d    = '0;
               state_d  = S_CONFIRM;
            end
         end
         S_CONFIRM: begin
            if (!match_sample_c) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = S_PRESSED;
               pulse_d    = 1'b1;
               deb_code_d = sample_q;
               held_d     = 1'b1;
`ifdef AUTO_REPEAT_EN
               rep_d      = REP_W'(REPEAT_DELAY - 1);
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_PRESSED: begin
            // A different code is treated as a release of the held key.
            if (!match_deb_c) begin
               cnt_d   = '0;
               state_d = S_RELEASE_CONFIRM;
            end
`ifdef AUTO_REPEAT_EN
            else if (rep_q == '0) begin
               pulse_d = 1'b1;
               rep_d   = REP_W'(REPEAT_RATE - 1);
            end else begin
               rep_d = rep_q - REP_W'(1);
            end
`endif
         end
         S_RELEASE_CONFIRM: begin
            // Repeat counter is frozen here so release glitches do not restart it.
            if (match_deb_c) begin
               state_d = S_PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               held_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.pulse    = pulse_q;
   assign bus.deb_code = deb_code_q;
   assign bus.held     = held_q;

endmodule
